// File: rtl/bcd_convert_ctrl.sv
// Sequential binary-to-BCD converter (double-dabble, one iteration per clock).
// Accepts one value over valid/ready, presents registered BCD digits and a sign flag.
module bcd_convert_ctrl #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter bit SIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_negative,
  output logic [4*DIGITS-1:0]   out_digits,
  output logic                  busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] bin;
  logic [BW-1:0]   bcd;
  logic            neg;

  logic            in_neg;
  logic [WIDTH-1:0] in_mag;
  logic [BW-1:0]   bcd_adj;
  logic [BW-1:0]   bcd_nxt;
  logic [WIDTH-1:0] bin_nxt;

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    in_neg  = SIGNED && in_data[WIDTH-1];
    in_mag  = in_neg ? (~in_data + 1'b1) : in_data;
    bcd_adj = add3(bcd);
    bcd_nxt = {bcd_adj[BW-2:0], bin[WIDTH-1]};
    bin_nxt = {bin[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      out_negative <= 1'b0;
      out_digits   <= '0;
      cnt          <= '0;
      bin          <= '0;
      bcd          <= '0;
      neg          <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            cnt      <= '0;
            bin      <= in_mag;
            bcd      <= '0;
            neg      <= in_neg;
          end
        end
        SHIFT: begin
          bcd <= bcd_nxt;
          bin <= bin_nxt;
          cnt <= cnt + 1'b1;
          // Last iteration lands straight in the output register.
          if (cnt == CW'(WIDTH - 1)) begin
            state        <= DONE;
            busy         <= 1'b0;
            out_valid    <= 1'b1;
            out_digits   <= bcd_nxt;
            out_negative <= neg;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Directed bench for bcd_convert_ctrl: signed and unsigned instances side by side.
// Table vectors plus hand sequences for stall, back-to-back and mid-conversion reset.
module tb_bcd_convert_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        in_ready_s, out_valid_s, out_negative_s, busy_s;
  logic [19:0] out_digits_s;
  logic        in_ready_u, out_valid_u, out_negative_u, busy_u;
  logic [19:0] out_digits_u;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bcd_convert_ctrl #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b1)) u_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_negative(out_negative_s), .out_digits(out_digits_s),
    .busy(busy_s)
  );

  bcd_convert_ctrl #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) u_u (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
    .out_valid(out_valid_u), .out_ready(out_ready),
    .out_negative(out_negative_u), .out_digits(out_digits_u),
    .busy(busy_u)
  );

  typedef struct {
    logic [15:0] data;
    logic [19:0] dig_s;
    logic        neg_s;
    logic [19:0] dig_u;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int hold);
    int n;
    @(negedge clk);
    chk("pre_ready_s", 32'(in_ready_s), 32'd1);
    in_valid  = 1'b1;
    in_data   = v.data;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("busy_after_accept", 32'(busy_s), 32'd1);
    n = 0;
    while (!out_valid_s && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), 32'd16);
    chk("valid_u", 32'(out_valid_u), 32'd1);
    chk("digits_s", 32'(out_digits_s), 32'(v.dig_s));
    chk("neg_s", 32'(out_negative_s), 32'(v.neg_s));
    chk("digits_u", 32'(out_digits_u), 32'(v.dig_u));
    chk("neg_u", 32'(out_negative_u), 32'd0);
    chk("done_busy", 32'(busy_s), 32'd0);
    chk("done_in_ready", 32'(in_ready_s), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      in_valid = k[0];
      in_data  = 16'h1111;
      @(posedge clk);
      #1;
      chk("stall_valid", 32'(out_valid_s), 32'd1);
      chk("stall_digits", 32'(out_digits_s), 32'(v.dig_s));
      chk("stall_in_ready", 32'(in_ready_s), 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_hs_valid", 32'(out_valid_s), 32'd0);
    chk("post_hs_in_ready", 32'(in_ready_s), 32'd1);
    chk("post_hs_digits", 32'(out_digits_s), 32'(v.dig_s));
  endtask

  initial begin
    int acc[2];
    int na;
    int nr;
    logic [19:0] res[2];

    vecs[0] = '{16'd1234, 20'h01234, 1'b0, 20'h01234};
    vecs[1] = '{16'hFFFF, 20'h00001, 1'b1, 20'h65535};
    vecs[2] = '{16'h8000, 20'h32768, 1'b1, 20'h32768};
    vecs[3] = '{16'd0,    20'h00000, 1'b0, 20'h00000};
    vecs[4] = '{16'd9,    20'h00009, 1'b0, 20'h00009};
    vecs[5] = '{16'hFFFE, 20'h00002, 1'b1, 20'h65534};
    vecs[6] = '{16'h7FFF, 20'h32767, 1'b0, 20'h32767};
    vecs[7] = '{16'd777,  20'h00777, 1'b0, 20'h00777};

    #12;
    chk("rst_valid", 32'(out_valid_s), 32'd0);
    chk("rst_busy", 32'(busy_s), 32'd0);
    chk("rst_digits", 32'(out_digits_s), 32'd0);
    chk("rst_neg", 32'(out_negative_s), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready_s), 32'd1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], (i == 0) ? 5 : 0);

    na = 0;
    nr = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (na < 2);
      in_data   = (na == 0) ? 16'd100 : 16'd42;
      if (in_ready_s && in_valid && na < 2) begin
        acc[na] = cyc;
        na++;
      end
      if (out_valid_s && nr < 2) begin
        res[nr] = out_digits_s;
        nr++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_accepts", 32'(na), 32'd2);
    chk("b2b_results", 32'(nr), 32'd2);
    if (na == 2) chk("b2b_spacing", 32'(acc[1] - acc[0]), 32'd18);
    if (nr == 2) begin
      chk("b2b_res0", 32'(res[0]), 32'h00100);
      chk("b2b_res1", 32'(res[1]), 32'h00042);
    end

    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'd5555;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid_s), 32'd0);
    chk("abort_busy", 32'(busy_s), 32'd0);
    chk("abort_digits", 32'(out_digits_s), 32'd0);
    chk("abort_neg", 32'(out_negative_s), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nr = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid_s) nr++;
    end
    chk("abort_no_stray", 32'(nr), 32'd0);
    run_vec(vecs[7], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
